// File: rtl/valid_ready_arbiter.sv
// Round-robin N:1 valid/ready arbiter; the grant locks while the downstream stalls.
// Define VALID_READY_ARBITER_PACKET_EN to add write_last/read_last and hold the grant for a whole packet.
module valid_ready_arbiter #(
  parameter int WIDTH   = 8,
  parameter int SOURCES = 4,
  localparam int GW     = (SOURCES > 1) ? $clog2(SOURCES) : 1
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [SOURCES*WIDTH-1:0] write_data,
  input  logic [SOURCES-1:0]       write_valid,
  output logic [SOURCES-1:0]       write_ready,
`ifdef VALID_READY_ARBITER_PACKET_EN
  input  logic [SOURCES-1:0]       write_last,
  output logic                     read_last,
`endif
  output logic [WIDTH-1:0]         read_data,
  output logic                     read_valid,
  input  logic                     read_ready,
  output logic [GW-1:0]            read_grant
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t state_reg, state_next;
  logic [GW-1:0] ptr_reg, ptr_next;
  logic [GW-1:0] lock_reg, lock_next;

  logic [SOURCES-1:0] ptr_mask;
  logic [SOURCES-1:0] masked_valid;
  logic [SOURCES-1:0] pick_src;
  logic [SOURCES-1:0] pick_oh;
  logic [SOURCES-1:0] grant_oh;
  logic [GW-1:0]      rr_grant;
  logic [GW-1:0]      grant;
  logic [GW-1:0]      grant_inc;
  logic [WIDTH-1:0]   sel_data;
  logic               sel_valid;
  logic               sel_last;
  logic               transfer;

  logic [GW-1:0][SOURCES-1:0]    enc_col;
  logic [WIDTH-1:0][SOURCES-1:0] data_col;

  // Sources at or above the pointer win first; otherwise wrap to the lowest valid source.
  assign ptr_mask     = ~((SOURCES'(1) << ptr_reg) - SOURCES'(1));
  assign masked_valid = write_valid & ptr_mask;
  assign pick_src     = (|masked_valid) ? masked_valid : write_valid;
  assign pick_oh      = pick_src & (~pick_src + SOURCES'(1));

  generate
    for (genvar gi = 0; gi < SOURCES; gi++) begin : g_src
      assign grant_oh[gi] = (grant == GW'(gi));
      for (genvar gb = 0; gb < GW; gb++) begin : g_enc
        assign enc_col[gb][gi] = (((gi >> gb) % 2) == 1) ? pick_oh[gi] : 1'b0;
      end
      for (genvar gb = 0; gb < WIDTH; gb++) begin : g_dat
        assign data_col[gb][gi] = grant_oh[gi] & write_data[gi*WIDTH + gb];
      end
    end
    for (genvar gb = 0; gb < GW; gb++) begin : g_enc_or
      assign rr_grant[gb] = |enc_col[gb];
    end
    for (genvar gb = 0; gb < WIDTH; gb++) begin : g_dat_or
      assign sel_data[gb] = |data_col[gb];
    end
  endgenerate

  assign grant     = (state_reg == LOCKED) ? lock_reg : rr_grant;
  assign sel_valid = |(write_valid & grant_oh);
  assign transfer  = sel_valid & read_ready;
  assign grant_inc = (grant == GW'(SOURCES - 1)) ? '0 : grant + GW'(1);

`ifdef VALID_READY_ARBITER_PACKET_EN
  assign sel_last = |(write_last & grant_oh);
`else
  assign sel_last = 1'b1;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      lock_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      lock_reg  <= lock_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    lock_next  = lock_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        // Stall or mid-packet beat: freeze the current grant until it completes.
        if ((sel_valid && !read_ready) || (transfer && !sel_last)) begin
          state_next = LOCKED;
          lock_next  = grant;
        end
      end
      LOCKED: begin
        if (transfer && sel_last) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (transfer && sel_last) begin
      ptr_next = grant_inc;
    end
  end

  always_comb begin
    read_grant  = grant;
    read_data   = sel_data;
    read_valid  = sel_valid & resetn;
    write_ready = resetn ? (grant_oh & {SOURCES{read_ready}}) : '0;
`ifdef VALID_READY_ARBITER_PACKET_EN
    read_last   = sel_last;
`endif
  end

endmodule

// File: tb/tb_valid_ready_arbiter.sv
// Directed self-checking bench for valid_ready_arbiter: 4-source, 3-source and 1-source instances.
// Packet checks switch on with VALID_READY_ARBITER_PACKET_EN.
module tb_valid_ready_arbiter;

  logic clock;
  logic resetn;
  int   tests;
  int   fails;

  logic [31:0] a_wdata;
  logic [3:0]  a_wvalid;
  logic [3:0]  a_wready;
  logic [3:0]  a_wlast;
  logic        a_rlast;
  logic [7:0]  a_rdata;
  logic        a_rvalid;
  logic        a_rready;
  logic [1:0]  a_rgrant;

  logic [23:0] b_wdata;
  logic [2:0]  b_wvalid;
  logic [2:0]  b_wready;
  logic [2:0]  b_wlast;
  logic        b_rlast;
  logic [7:0]  b_rdata;
  logic        b_rvalid;
  logic        b_rready;
  logic [1:0]  b_rgrant;

  logic [7:0]  c_wdata;
  logic [0:0]  c_wvalid;
  logic [0:0]  c_wready;
  logic [0:0]  c_wlast;
  logic        c_rlast;
  logic [7:0]  c_rdata;
  logic        c_rvalid;
  logic        c_rready;
  logic [0:0]  c_rgrant;

  valid_ready_arbiter #(.WIDTH(8), .SOURCES(4)) dut_a (
    .clock(clock), .resetn(resetn),
    .write_data(a_wdata), .write_valid(a_wvalid), .write_ready(a_wready),
`ifdef VALID_READY_ARBITER_PACKET_EN
    .write_last(a_wlast), .read_last(a_rlast),
`endif
    .read_data(a_rdata), .read_valid(a_rvalid), .read_ready(a_rready), .read_grant(a_rgrant)
  );

  valid_ready_arbiter #(.WIDTH(8), .SOURCES(3)) dut_b (
    .clock(clock), .resetn(resetn),
    .write_data(b_wdata), .write_valid(b_wvalid), .write_ready(b_wready),
`ifdef VALID_READY_ARBITER_PACKET_EN
    .write_last(b_wlast), .read_last(b_rlast),
`endif
    .read_data(b_rdata), .read_valid(b_rvalid), .read_ready(b_rready), .read_grant(b_rgrant)
  );

  valid_ready_arbiter #(.WIDTH(8), .SOURCES(1)) dut_c (
    .clock(clock), .resetn(resetn),
    .write_data(c_wdata), .write_valid(c_wvalid), .write_ready(c_wready),
`ifdef VALID_READY_ARBITER_PACKET_EN
    .write_last(c_wlast), .read_last(c_rlast),
`endif
    .read_data(c_rdata), .read_valid(c_rvalid), .read_ready(c_rready), .read_grant(c_rgrant)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic test_reset();
    resetn   = 1'b0;
    a_wvalid = 4'hF; a_rready = 1'b1;
    b_wvalid = 3'b000; b_rready = 1'b1;
    c_wvalid = 1'b1; c_rready = 1'b1;
    @(negedge clock); #1;
    tests++;
    if (a_wready !== 4'b0000 || a_rvalid !== 1'b0) begin
      $display("FAIL reset_a: wready=%b rvalid=%b expected 0000/0", a_wready, a_rvalid); fails++;
    end
    tests++;
    if (c_wready !== 1'b0 || c_rvalid !== 1'b0) begin
      $display("FAIL reset_c: wready=%b rvalid=%b expected 0/0", c_wready, c_rvalid); fails++;
    end
    @(negedge clock);
    resetn = 1'b1; a_wvalid = 4'h0; c_wvalid = 1'b0;
    #1;
    tests++;
    if (a_rvalid !== 1'b0 || a_rgrant !== 2'd0 || a_wready !== 4'b0001) begin
      $display("FAIL idle_after_reset: rvalid=%b grant=%0d wready=%b expected 0/0/0001",
               a_rvalid, a_rgrant, a_wready); fails++;
    end
  endtask

  task automatic test_round_robin();
    int exp_g;
    logic [7:0] exp_d;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      a_wvalid = 4'hF; a_rready = 1'b1;
      #1;
      exp_g = k % 4;
      exp_d = 8'hA0 + 8'(exp_g);
      $display("[TB] rr cycle %0d grant=%0d data=%h", k, a_rgrant, a_rdata);
      tests++;
      if (a_rgrant !== 2'(exp_g) || a_rdata !== exp_d || a_rvalid !== 1'b1 ||
          a_wready !== (4'b0001 << exp_g)) begin
        $display("FAIL round_robin[%0d]: grant=%0d data=%h valid=%b wready=%b expected %0d/%h/1/%b",
                 k, a_rgrant, a_rdata, a_rvalid, a_wready, exp_g, exp_d, 4'b0001 << exp_g);
        fails++;
      end
    end
  endtask

  task automatic test_lock_hold();
    logic [3:0] vv [5] = '{4'b1010, 4'b1011, 4'b1011, 4'b1011, 4'b1011};
    logic       rr [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] eg [5] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3};
    logic [3:0] ew [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b1000};
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      a_wvalid = vv[k]; a_rready = rr[k];
      #1;
      $display("[TB] lock cycle %0d grant=%0d data=%h wready=%b", k, a_rgrant, a_rdata, a_wready);
      tests++;
      if (a_rgrant !== eg[k] || a_rdata !== (8'hA0 + 8'(eg[k])) || a_rvalid !== 1'b1 ||
          a_wready !== ew[k]) begin
        $display("FAIL lock_hold[%0d]: grant=%0d data=%h valid=%b wready=%b expected %0d/%h/1/%b",
                 k, a_rgrant, a_rdata, a_rvalid, a_wready, eg[k], 8'hA0 + 8'(eg[k]), ew[k]);
        fails++;
      end
    end
  endtask

  task automatic test_protocol_violation();
    logic [3:0] vv [6] = '{4'b0001, 4'b0110, 4'b0110, 4'b0111, 4'b0110, 4'b0000};
    logic       rr [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [1:0] eg [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
    logic       ev [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] ew [6] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0010, 4'b0001};
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      a_wvalid = vv[k]; a_rready = rr[k];
      #1;
      $display("[TB] drop cycle %0d grant=%0d valid=%b wready=%b", k, a_rgrant, a_rvalid, a_wready);
      tests++;
      if (a_rgrant !== eg[k] || a_rvalid !== ev[k] || a_wready !== ew[k]) begin
        $display("FAIL valid_drop[%0d]: grant=%0d valid=%b wready=%b expected %0d/%b/%b",
                 k, a_rgrant, a_rvalid, a_wready, eg[k], ev[k], ew[k]);
        fails++;
      end
    end
  endtask

  task automatic test_reset_mid_lock();
    @(negedge clock);
    a_wvalid = 4'b0100; a_rready = 1'b0;
    #1;
    tests++;
    if (a_rgrant !== 2'd2 || a_rvalid !== 1'b1) begin
      $display("FAIL pre_lock: grant=%0d valid=%b expected 2/1", a_rgrant, a_rvalid); fails++;
    end
    @(negedge clock);
    a_wvalid = 4'hF;
    #1;
    tests++;
    if (a_rgrant !== 2'd2 || a_rdata !== 8'hA2) begin
      $display("FAIL locked_src2: grant=%0d data=%h expected 2/a2", a_rgrant, a_rdata); fails++;
    end
    resetn = 1'b0; a_rready = 1'b1;
    #1;
    tests++;
    if (a_wready !== 4'b0000 || a_rvalid !== 1'b0) begin
      $display("FAIL reset_in_lock: wready=%b valid=%b expected 0000/0", a_wready, a_rvalid); fails++;
    end
    @(negedge clock);
    resetn = 1'b1;
    #1;
    tests++;
    if (a_rgrant !== 2'd0 || a_wready !== 4'b0001 || a_rvalid !== 1'b1) begin
      $display("FAIL first_after_reset: grant=%0d wready=%b valid=%b expected 0/0001/1",
               a_rgrant, a_wready, a_rvalid); fails++;
    end
  endtask

  task automatic test_packet();
    logic       l1 [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
`ifdef VALID_READY_ARBITER_PACKET_EN
    logic [1:0] eg [4] = '{2'd1, 2'd1, 2'd1, 2'd0};
    logic       el [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
    logic [1:0] eg [4] = '{2'd1, 2'd0, 2'd1, 2'd0};
`endif
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      a_wvalid = 4'b0011; a_rready = 1'b1;
      a_wlast  = {2'b00, l1[k], 1'b1};
      #1;
      $display("[TB] packet beat %0d grant=%0d data=%h", k, a_rgrant, a_rdata);
      tests++;
      if (a_rgrant !== eg[k] || a_rdata !== (8'hA0 + 8'(eg[k]))) begin
        $display("FAIL packet[%0d]: grant=%0d data=%h expected %0d/%h",
                 k, a_rgrant, a_rdata, eg[k], 8'hA0 + 8'(eg[k]));
        fails++;
      end
`ifdef VALID_READY_ARBITER_PACKET_EN
      tests++;
      if (a_rlast !== el[k]) begin
        $display("FAIL read_last[%0d]: got %b expected %b", k, a_rlast, el[k]); fails++;
      end
`endif
    end
    a_wlast = 4'hF;
  endtask

  task automatic test_wrap();
    logic [2:0] vv [5] = '{3'b100, 3'b100, 3'b101, 3'b101, 3'b011};
    logic [1:0] eg [5] = '{2'd2, 2'd2, 2'd0, 2'd2, 2'd0};
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      b_wvalid = vv[k]; b_rready = 1'b1;
      #1;
      $display("[TB] wrap cycle %0d grant=%0d data=%h", k, b_rgrant, b_rdata);
      tests++;
      if (b_rgrant !== eg[k] || b_rdata !== (8'hB0 + 8'(eg[k])) ||
          b_wready !== (3'b001 << eg[k])) begin
        $display("FAIL wrap3[%0d]: grant=%0d data=%h wready=%b expected %0d/%h/%b",
                 k, b_rgrant, b_rdata, b_wready, eg[k], 8'hB0 + 8'(eg[k]), 3'b001 << eg[k]);
        fails++;
      end
    end
    b_wvalid = 3'b000;
  endtask

  task automatic test_single();
    logic vv [3] = '{1'b1, 1'b1, 1'b0};
    logic rr [3] = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      c_wvalid = vv[k]; c_rready = rr[k];
      #1;
      $display("[TB] single cycle %0d valid=%b ready=%b", k, c_rvalid, c_wready);
      tests++;
      if (c_rvalid !== vv[k] || c_wready !== rr[k] || c_rgrant !== 1'b0 || c_rdata !== 8'hC5) begin
        $display("FAIL single[%0d]: valid=%b wready=%b grant=%0d data=%h expected %b/%b/0/c5",
                 k, c_rvalid, c_wready, c_rgrant, c_rdata, vv[k], rr[k]);
        fails++;
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    a_wdata = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    b_wdata = {8'hB2, 8'hB1, 8'hB0};
    c_wdata = 8'hC5;
    a_wlast = 4'hF; b_wlast = 3'b111; c_wlast = 1'b1;
    test_reset();
    test_round_robin();
    test_lock_hold();
    test_protocol_violation();
    test_reset_mid_lock();
    test_packet();
    test_wrap();
    test_single();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
